// File: rtl/cmp_pkg.sv
// Shared definitions for the compare-sharing arbiter: opcodes, result
// constants and the requester-port identifier.
package cmp_pkg;

  localparam logic [3:0] CMP_SLT  = 4'b1000;
  localparam logic [3:0] CMP_SLTU = 4'b1001;
  localparam logic [3:0] CMP_EQ   = 4'b1010;
  localparam logic [3:0] CMP_NE   = 4'b1011;
  localparam logic [3:0] CMP_GE   = 4'b1100;
  localparam logic [3:0] CMP_GEU  = 4'b1101;

  localparam logic [31:0] CMP_TRUE  = 32'h0000_0001;
  localparam logic [31:0] CMP_FALSE = 32'h0000_0000;

  // Requester port identifier, also the encoding of the round-robin pointer.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/cmp_core.sv
// Single shared comparator: signed/unsigned ordering and equality compares.
// Unknown opcodes return CMP_FALSE.
module cmp_core
  import cmp_pkg::*;
(
  input  logic [31:0] rs_1,
  input  logic [31:0] rs_2,
  input  logic [3:0]  alu_ctrl,
  output logic [31:0] result
);

  logic lt_s;
  logic lt_u;
  logic eq;

  assign lt_s = $signed(rs_1) < $signed(rs_2);
  assign lt_u = rs_1 < rs_2;
  assign eq   = rs_1 == rs_2;

  // Opcode decode to a zero-extended boolean result.
  always_comb begin
    result = CMP_FALSE;
    case (alu_ctrl)
      CMP_SLT:  result = lt_s ? CMP_TRUE : CMP_FALSE;
      CMP_SLTU: result = lt_u ? CMP_TRUE : CMP_FALSE;
      CMP_EQ:   result = eq   ? CMP_TRUE : CMP_FALSE;
      CMP_NE:   result = eq   ? CMP_FALSE : CMP_TRUE;
      CMP_GE:   result = lt_s ? CMP_FALSE : CMP_TRUE;
      CMP_GEU:  result = lt_u ? CMP_FALSE : CMP_TRUE;
      default:  result = CMP_FALSE;
    endcase
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one comparator between the ALU-issue port (0)
// and the branch-resolution port (1), with a single registered, tagged
// response channel. Optional saturating performance counters are built
// when the macro CMP_ARB_PERF_EN is defined.
module cmp_share_arbiter
  import cmp_pkg::*;
#(
  parameter int TAG_W = 4
`ifdef CMP_ARB_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_rs_1,
  input  logic [31:0]       req0_rs_2,
  input  logic [3:0]        req0_alu_ctrl,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_rs_1,
  input  logic [31:0]       req1_rs_2,
  input  logic [3:0]        req1_alu_ctrl,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [31:0]       rsp_result
`ifdef CMP_ARB_PERF_EN
  , output logic [CNT_W-1:0] perf_grant0
  , output logic [CNT_W-1:0] perf_grant1
  , output logic [CNT_W-1:0] perf_conflict
`endif
);

  port_e             last;
  port_e             sel;
  logic              can_issue;
  logic              grant0;
  logic              grant1;
  logic              accept0;
  logic              accept1;
  logic              accept;
  logic [31:0]       mux_rs_1;
  logic [31:0]       mux_rs_2;
  logic [3:0]        mux_ctrl;
  logic [TAG_W-1:0]  mux_tag;
  logic [31:0]       cmp_result;

  // Grant selection: a lone requester wins; on a conflict the port not
  // served last wins. Readys are gated by reset and response backpressure.
  always_comb begin
    can_issue  = !rsp_valid || rsp_ready;
    grant0     = req0_valid && (!req1_valid || (last == PORT1));
    grant1     = req1_valid && !grant0;
    req0_ready = rst_n && can_issue && grant0;
    req1_ready = rst_n && can_issue && grant1;
    accept0    = req0_valid && req0_ready;
    accept1    = req1_valid && req1_ready;
    accept     = accept0 || accept1;
    sel        = grant1 ? PORT1 : PORT0;
  end

  // Operand mux in front of the single shared comparator.
  always_comb begin
    mux_rs_1 = req0_rs_1;
    mux_rs_2 = req0_rs_2;
    mux_ctrl = req0_alu_ctrl;
    mux_tag  = req0_tag;
    if (sel == PORT1) begin
      mux_rs_1 = req1_rs_1;
      mux_rs_2 = req1_rs_2;
      mux_ctrl = req1_alu_ctrl;
      mux_tag  = req1_tag;
    end
  end

  cmp_core u_cmp_core (
    .rs_1     (mux_rs_1),
    .rs_2     (mux_rs_2),
    .alu_ctrl (mux_ctrl),
    .result   (cmp_result)
  );

  // Round-robin pointer; reset to PORT1 so port 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= PORT1;
    end else if (accept) begin
      last <= sel;
    end
  end

  // Response register: load on accept (overwriting a consumed response in
  // the same edge), otherwise drain on rsp_ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= sel;
      rsp_tag    <= mux_tag;
      rsp_result <= cmp_result;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef CMP_ARB_PERF_EN
  logic conflict;
  assign conflict = req0_valid && req1_valid && can_issue;

  // Saturating accept and conflict counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (accept0 && (perf_grant0 != '1)) begin
        perf_grant0 <= perf_grant0 + CNT_W'(1);
      end
      if (accept1 && (perf_grant1 != '1)) begin
        perf_grant1 <= perf_grant1 + CNT_W'(1);
      end
      if (conflict && (perf_conflict != '1)) begin
        perf_conflict <= perf_conflict + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Testbench for cmp_share_arbiter: scoreboard of expected responses plus a
// vector table and directed sequences for arbitration, backpressure, reset
// and (with CMP_ARB_PERF_EN) the saturating counters.
module tb_cmp_share_arbiter;
  import cmp_pkg::*;

  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [31:0]       req0_rs_1, req0_rs_2, req1_rs_1, req1_rs_2;
  logic [3:0]        req0_alu_ctrl, req1_alu_ctrl;
  logic [TAG_W-1:0]  req0_tag, req1_tag;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [TAG_W-1:0]  rsp_tag;
  logic [31:0]       rsp_result;
`ifdef CMP_ARB_PERF_EN
  logic [1:0]        perf_grant0, perf_grant1, perf_conflict;
`endif

  always #5 clk = ~clk;

`ifdef CMP_ARB_PERF_EN
  cmp_share_arbiter #(.TAG_W(TAG_W), .CNT_W(2)) dut (
`else
  cmp_share_arbiter #(.TAG_W(TAG_W)) dut (
`endif
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_rs_1     (req0_rs_1),
    .req0_rs_2     (req0_rs_2),
    .req0_alu_ctrl (req0_alu_ctrl),
    .req0_tag      (req0_tag),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_rs_1     (req1_rs_1),
    .req1_rs_2     (req1_rs_2),
    .req1_alu_ctrl (req1_alu_ctrl),
    .req1_tag      (req1_tag),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_tag       (rsp_tag),
    .rsp_result    (rsp_result)
`ifdef CMP_ARB_PERF_EN
    , .perf_grant0   (perf_grant0)
    , .perf_grant1   (perf_grant1)
    , .perf_conflict (perf_conflict)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result for whatever payload is currently presented on each port.
  logic [31:0] exp0, exp1;

  typedef struct {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } rsp_t;

  rsp_t sb[$];
  logic m_rv   = 1'b0;
  logic m_last = 1'b1;

  // Reference arbiter/scoreboard evaluated mid-cycle, predicting the next edge.
  always @(negedge clk) begin
    logic e_ci, e_g0, e_g1;
    rsp_t r;
    e_ci = !m_rv || rsp_ready;
    e_g0 = req0_valid && (!req1_valid || m_last);
    e_g1 = req1_valid && !e_g0;
    if (!rst_n) begin
      e_g0 = 1'b0;
      e_g1 = 1'b0;
    end else begin
      e_g0 = e_g0 && e_ci;
      e_g1 = e_g1 && e_ci;
    end
    check("req0_ready", {31'b0, req0_ready}, {31'b0, e_g0});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, e_g1});
    check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rv});
    if (m_rv) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        check("rsp_id", {31'b0, rsp_id}, {31'b0, sb[0].id});
        check("rsp_tag", {28'b0, rsp_tag}, {28'b0, sb[0].tag});
        check("rsp_result", rsp_result, sb[0].res);
      end
    end
    if (!rst_n) begin
      m_rv   = 1'b0;
      m_last = 1'b1;
      sb.delete();
    end else begin
      if (m_rv && rsp_ready && sb.size() != 0) void'(sb.pop_front());
      if (e_g0) begin
        r.id = 1'b0; r.tag = req0_tag; r.res = exp0;
        sb.push_back(r);
        m_last = 1'b0;
        m_rv   = 1'b1;
      end else if (e_g1) begin
        r.id = 1'b1; r.tag = req1_tag; r.res = exp1;
        sb.push_back(r);
        m_last = 1'b1;
        m_rv   = 1'b1;
      end else if (rsp_ready) begin
        m_rv = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] e);
    req0_valid = v; req0_alu_ctrl = op; req0_rs_1 = a; req0_rs_2 = b; req0_tag = t; exp0 = e;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t, input logic [31:0] e);
    req1_valid = v; req1_alu_ctrl = op; req1_rs_1 = a; req1_rs_2 = b; req1_tag = t; exp1 = e;
  endtask

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [TAG_W-1:0] t0, t1, last_t1;

    vecs[0]  = '{1'b0, CMP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h1};
    vecs[1]  = '{1'b0, CMP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0};
    vecs[2]  = '{1'b1, 4'b0111,  32'h8000_0000, 32'h8000_0000, 32'h0};
    vecs[3]  = '{1'b1, CMP_EQ,   32'h8000_0000, 32'h8000_0000, 32'h1};
    vecs[4]  = '{1'b0, CMP_NE,   32'h8000_0000, 32'h8000_0000, 32'h0};
    vecs[5]  = '{1'b1, CMP_GE,   32'h8000_0000, 32'h8000_0000, 32'h1};
    vecs[6]  = '{1'b0, CMP_GEU,  32'h8000_0000, 32'h8000_0000, 32'h1};
    vecs[7]  = '{1'b1, CMP_SLT,  32'h0000_0005, 32'h0000_0005, 32'h0};
    vecs[8]  = '{1'b0, CMP_SLTU, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1};
    vecs[9]  = '{1'b1, CMP_GE,   32'h0000_0001, 32'hFFFF_FFFF, 32'h1};
    vecs[10] = '{1'b0, CMP_GEU,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b1, CMP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    vecs[12] = '{1'b0, CMP_NE,   32'h0000_0001, 32'h0000_0002, 32'h1};
    vecs[13] = '{1'b1, 4'b1111,  32'h0000_0000, 32'h0000_0001, 32'h0};
    vecs[14] = '{1'b0, CMP_EQ,   32'h0000_0000, 32'h0000_0001, 32'h0};

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive0(1'b0, 4'h0, '0, '0, '0, '0);
    drive1(1'b0, 4'h0, '0, '0, '0, '0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Reset values.
    @(negedge clk);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_id", {31'b0, rsp_id}, 32'd0);
    check("reset rsp_tag", {28'b0, rsp_tag}, 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    cyc();

    // Vector table: one request at a time, response consumed every cycle.
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) begin
      if (vecs[i].port == 1'b0)
        drive0(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].exp);
      else
        drive1(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].exp);
      @(negedge clk);
      if (vecs[i].port == 1'b0) check("vec ready0", {31'b0, req0_ready}, 32'd1);
      else                      check("vec ready1", {31'b0, req1_ready}, 32'd1);
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check("vec result", rsp_result, vecs[i].exp);
      check("vec id", {31'b0, rsp_id}, {31'b0, vecs[i].port});
      cyc();
    end

    // Give port 1 the last grant so the reset-restored priority is observable.
    drive1(1'b1, CMP_EQ, 32'h3, 32'h3, 4'h2, 32'h1);
    cyc();
    req1_valid = 1'b0;

    // Reset with a pending, unconsumed response.
    rsp_ready = 1'b0;
    drive0(1'b1, CMP_SLT, 32'h1, 32'h2, 4'h3, 32'h1);
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    check("pending rsp_valid", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    cyc();

    // Conflict: both valid for 4 cycles, grants alternate starting at port 0.
    rsp_ready = 1'b1;
    t0 = 4'h0;
    t1 = 4'h8;
    last_t1 = t1;
    drive0(1'b1, CMP_SLT, 32'h1, 32'h2, t0, 32'h1);
    drive1(1'b1, CMP_EQ,  32'h1, 32'h2, t1, 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("alt ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      cyc();
      if (i % 2 == 0) begin
        t0 = t0 + 4'h1;
        req0_tag = t0;
      end else begin
        last_t1 = t1;
        t1 = t1 + 4'h1;
        req1_tag = t1;
      end
    end

    // Backpressure with both ports still valid: everything frozen.
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp ready0", {31'b0, req0_ready}, 32'd0);
      check("bp ready1", {31'b0, req1_ready}, 32'd0);
      check("bp rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp rsp_id", {31'b0, rsp_id}, 32'd1);
      check("bp rsp_tag", {28'b0, rsp_tag}, {28'b0, last_t1});
      check("bp rsp_result", rsp_result, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release ready0", {31'b0, req0_ready}, 32'd1);
    check("release ready1", {31'b0, req1_ready}, 32'd0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc(); cyc();

`ifdef CMP_ARB_PERF_EN
    // Saturating counters with a 2-bit width.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive0(1'b1, CMP_NE, 32'h1, 32'h2, 4'h1, 32'h1);
    drive1(1'b1, CMP_NE, 32'h5, 32'h5, 4'h9, 32'h0);
    for (int unsigned i = 0; i < 5; i++) cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("perf_conflict sat", {30'b0, perf_conflict}, 32'd3);
    check("perf_grant0 sat", {30'b0, perf_grant0}, 32'd3);
    check("perf_grant1", {30'b0, perf_grant1}, 32'd2);
    cyc(); cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
